mult_requester: RTL and testbench
=================================

// Module: mult_requester
// PURPOSE
//   Initiator side of the multiplier start/ready/ovf handshake. Conditions the raw active-low
//   board push-button, latches the operand switches, requests a multiplication from the
//   control FSM via an active-low start, waits for completion, then captures and holds the
//   2*DW product for the display path. Sits between board I/O and the multiplier top level.
// PARAMETERS
//   DW         8     operand width; must equal pkg_mult::DW
//   DB_CYCLES  4     consecutive stable cycles before debounced button changes (>=2; 50000 on board)
//   TO_CYCLES  64    watchdog limit in REQ and RUN states; must be > DW+4
// PORTS
//   i_clk          in   1     system clock
//   i_rst          in   1     asynchronous, active-low reset
//   i_btn          in   1     raw push-button, active-low (0 = pressed), asynchronous
//   i_op_a         in   DW    multiplicand switches
//   i_op_b         in   DW    multiplier switches
//   i_ready        in   1     control FSM is in IDLE
//   i_ovf          in   1     control FSM step counter exceeded DW (product complete)
//   i_product      in   2*DW  datapath product
//   o_start        out  1     start request to control FSM, active-low
//   o_op_a/o_op_b  out  DW    operands held stable for the whole operation
//   o_result       out  2*DW  captured product, unsigned
//   o_valid        out  1     o_result holds a completed product
//   o_busy         out  1     state != IDLE
//   o_err          out  1     sticky: dropped press or watchdog expiry
// BEHAVIOUR
//   Reset (async, i_rst=0): state IDLE; o_start=1; o_op_a/b=0; o_result=0; o_valid=0; o_busy=0;
//     o_err=0; synchroniser FFs and debounced level = 1 (released); debounce/watchdog counters = 0.
//   Conditioning: 2-FF synchroniser on i_btn. Debounce counter increments while synced level !=
//     debounced level, clears otherwise; at DB_CYCLES-1 debounced level takes synced value and
//     counter clears. press = 1-cycle pulse on debounced 1->0 edge. Release generates nothing.
//   FSM (Moore, outputs decoded from registered state; o_start=0 only in REQ):
//     IDLE    press & i_ready -> latch i_op_a/b, o_valid<=0, o_err<=0, go REQ.
//             press & !i_ready -> stay IDLE, o_err<=1, operands unchanged.
//     REQ     i_ready==0 (controller left IDLE) -> RUN. Watchdog expiry -> IDLE, o_err<=1.
//     RUN     i_ovf==1 -> CAPTURE. Watchdog expiry -> IDLE, o_err<=1, o_valid stays 0.
//     CAPTURE one cycle: o_result<=i_product, o_valid<=1 -> DRAIN.
//     DRAIN   i_ready==1 -> IDLE (controller back in IDLE; prevents re-request on stale ovf).
//   Watchdog: clears on every state change, counts in REQ/RUN, expires at TO_CYCLES-1.
//   Press in any state other than IDLE: ignored, o_err<=1. Press and i_ovf in same cycle in
//     RUN: capture proceeds, o_err<=1.
//   Latency: press pulse in cycle t -> o_start=0 in t+1; product visible with o_valid=1 the
//     cycle after CAPTURE. o_result/o_valid hold until next accepted press.
//   Width rules: o_result is a straight 2*DW copy; no sign handling.
//   Reset mid-operation: immediate return to reset values; o_start released asynchronously.
// STRUCTURE
//   pkg_mult: add req_state_e {IDLE_R, REQ_R, RUN_R, CAPTURE_R, DRAIN_R}, typedef req_t struct
//     (state, wdog, op_a, op_b) alongside control_t; DW taken from package constant.
//   Sub-module btn_debounce (synchroniser + debounce + falling-edge pulse; params DB_CYCLES),
//     instantiated once; FSM, watchdog and capture registers in mult_requester.
// TESTING (DW=8, DB_CYCLES=4, TO_CYCLES=64, control FSM + datapath model attached)
//   1 op_a=13, op_b=11, clean press -> o_start low one handshake, o_result=143, o_valid=1, o_err=0.
//   2 i_btn bouncing 0/1 every 2 cycles for 20 cycles, then held 0 -> exactly one request.
//   3 second press during RUN (255*255) -> o_err=1, result 65025, only one o_start episode.
//   4 model never drops i_ready -> after 64 cycles in REQ: IDLE, o_start=1, o_err=1, o_valid=0.
//   5 i_rst low in RUN -> all outputs reset values next cycle; next press completes 2*3=6.

Source files
------------

// File: rtl/mult_requester_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkg_mult : shared widths, controller/requester state types, watchdog helper
// Revision : 1.0
// ---------------------------------------------------------------------------
package pkg_mult;

  localparam int DW     = 8;
  localparam int WDOG_W = 16;

  typedef enum logic [1:0] {
    C_IDLE,
    C_INIT,
    C_RUN,
    C_DONE
  } control_t;

  typedef enum logic [2:0] {
    IDLE_R,
    REQ_R,
    RUN_R,
    CAPTURE_R,
    DRAIN_R
  } req_state_e;

  typedef struct packed {
    req_state_e        state;
    logic [WDOG_W-1:0] wdog;
    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
  } req_t;

  function automatic logic wdog_expired(input logic [WDOG_W-1:0] cnt, input int limit);
    return cnt == WDOG_W'(limit - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_requester_btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser, stability debounce, press (1->0) pulse
// Revision     : 1.0
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pulse in the cycle the debounced level is about to fall; releases are silent.
  assign o_press = db_q & ~db_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_requester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_requester : button-driven initiator of the multiplier start/ready/ovf
//                  handshake; latches operands and holds the captured product
// Revision       : 1.0
// ---------------------------------------------------------------------------
module mult_requester
  import pkg_mult::*;
#(
  parameter int DW        = pkg_mult::DW,
  parameter int DB_CYCLES = 4,
  parameter int TO_CYCLES = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_btn,
  input  logic [DW-1:0]   i_op_a,
  input  logic [DW-1:0]   i_op_b,
  input  logic            i_ready,
  input  logic            i_ovf,
  input  logic [2*DW-1:0] i_product,
  output logic            o_start,
  output logic [DW-1:0]   o_op_a,
  output logic [DW-1:0]   o_op_b,
  output logic [2*DW-1:0] o_result,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_err
);

  logic            press;
  logic            wdog_exp;
  req_t            req_q, req_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_btn),
    .o_press(press)
  );

  assign wdog_exp = wdog_expired(req_q.wdog, TO_CYCLES);

  always_comb begin
    req_d    = req_q;
    result_d = result_q;
    valid_d  = valid_q;
    err_d    = err_q;

    if (press && (req_q.state != IDLE_R)) begin
      err_d = 1'b1;
    end

    case (req_q.state)
      IDLE_R: begin
        if (press) begin
          if (i_ready) begin
            req_d.op_a  = i_op_a;
            req_d.op_b  = i_op_b;
            valid_d     = 1'b0;
            err_d       = 1'b0;
            req_d.state = REQ_R;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ_R: begin
        if (!i_ready) begin
          req_d.state = RUN_R;
        end else if (wdog_exp) begin
          req_d.state = IDLE_R;
          err_d       = 1'b1;
        end else begin
          req_d.wdog = req_q.wdog + 1'b1;
        end
      end
      RUN_R: begin
        if (i_ovf) begin
          req_d.state = CAPTURE_R;
        end else if (wdog_exp) begin
          req_d.state = IDLE_R;
          err_d       = 1'b1;
        end else begin
          req_d.wdog = req_q.wdog + 1'b1;
        end
      end
      CAPTURE_R: begin
        result_d    = i_product;
        valid_d     = 1'b1;
        req_d.state = DRAIN_R;
      end
      DRAIN_R: begin
        // Wait for the controller to return to IDLE so a stale ovf cannot re-trigger.
        if (i_ready) begin
          req_d.state = IDLE_R;
        end
      end
      default: req_d.state = IDLE_R;
    endcase

    if (req_d.state != req_q.state) begin
      req_d.wdog = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      req_q    <= '{state: IDLE_R, wdog: '0, op_a: '0, op_b: '0};
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      req_q    <= req_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_start  = (req_q.state != REQ_R);
  assign o_busy   = (req_q.state != IDLE_R);
  assign o_op_a   = req_q.op_a;
  assign o_op_b   = req_q.op_b;
  assign o_result = result_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_requester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_requester : requester bench with a behavioural controller/datapath
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_mult_requester;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          btn;
  logic [DW-1:0] op_a, op_b;
  logic          ready, ovf;
  logic [2*DW-1:0] product;
  logic          o_start;
  logic [DW-1:0] o_op_a, o_op_b;
  logic [2*DW-1:0] o_result;
  logic          o_valid, o_busy, o_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2*DW-1:0] exp_q[$];

  mult_requester #(
    .DW(DW),
    .DB_CYCLES(4),
    .TO_CYCLES(64)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_btn    (btn),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_ready  (ready),
    .i_ovf    (ovf),
    .i_product(product),
    .o_start  (o_start),
    .o_op_a   (o_op_a),
    .o_op_b   (o_op_b),
    .o_result (o_result),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller + datapath model: IDLE -> BUSY (DW+1+extra steps) -> DONE (ovf) -> IDLE.
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} m_state_e;
  m_state_e        m_state;
  int              m_cnt;
  logic [2*DW-1:0] m_prod;
  int              extra = 0;
  bit              stuck = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE;
      m_cnt   <= 0;
      m_prod  <= '0;
    end else begin
      case (m_state)
        M_IDLE: if (!o_start && !stuck) begin
          m_state <= M_BUSY;
          m_cnt   <= 0;
          m_prod  <= (2*DW)'(o_op_a) * (2*DW)'(o_op_b);
        end
        M_BUSY: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt >= DW + extra) m_state <= M_DONE;
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  assign ready   = (m_state == M_IDLE);
  assign ovf     = (m_state == M_DONE);
  assign product = m_prod;

  // Start-handshake observation.
  int   start_episodes   = 0;
  int   start_low_cycles = 0;
  logic prev_start       = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_start && !o_start) start_episodes <= start_episodes + 1;
      if (!o_start) start_low_cycles <= start_low_cycles + 1;
    end
    prev_start <= o_start;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic press_btn();
    btn = 1'b0;
    repeat (10) @(negedge clk);
    btn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(o_valid && !o_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!(o_valid && !o_busy)) begin
      tests_failed++;
      $display("FAIL %s_timeout: valid=%0b busy=%0b, required valid=1 busy=0", name, o_valid, o_busy);
    end
  endtask

  task automatic check_result(input string name);
    logic [2*DW-1:0] exp;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard: result=%0d with no expected entry", name, o_result);
    end else begin
      exp = exp_q.pop_front();
      if (o_result !== exp) begin
        tests_failed++;
        $display("FAIL %s_result: got %0d, required %0d", name, o_result, exp);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    tests_run++;
    if (got !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    tests_run++;
    if (got != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_bit({name, "_start"}, o_start, 1'b1);
    check_bit({name, "_busy"},  o_busy,  1'b0);
    check_bit({name, "_valid"}, o_valid, 1'b0);
    check_bit({name, "_err"},   o_err,   1'b0);
    tests_run++;
    if (o_result !== '0 || o_op_a !== '0 || o_op_b !== '0) begin
      tests_failed++;
      $display("FAIL %s_data: result=%0d op_a=%0d op_b=%0d, required all 0", name, o_result, o_op_a, o_op_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b1;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int ep0 = start_episodes;
    op_a = 8'd13;
    op_b = 8'd11;
    exp_q.push_back(16'd143);
    press_btn();
    wait_done("basic");
    check_result("basic");
    check_bit("basic_err", o_err, 1'b0);
    check_int("basic_episodes", start_episodes - ep0, 1);
    check_int("basic_op_a_held", int'(o_op_a), 13);
    check_bit("basic_start_idle", o_start, 1'b1);
  endtask

  task automatic test_bounce();
    int ep0 = start_episodes;
    op_a = 8'd4;
    op_b = 8'd6;
    exp_q.push_back(16'd24);
    for (int i = 0; i < 10; i++) begin
      btn = i[0];
      repeat (2) @(negedge clk);
    end
    press_btn();
    wait_done("bounce");
    check_result("bounce");
    check_int("bounce_episodes", start_episodes - ep0, 1);
    check_bit("bounce_err", o_err, 1'b0);
  endtask

  task automatic test_press_during_run();
    int ep0 = start_episodes;
    extra = 40;
    op_a  = 8'd255;
    op_b  = 8'd255;
    exp_q.push_back(16'd65025);
    press_btn();
    check_bit("run_busy_before_2nd", o_busy, 1'b1);
    op_a = 8'd1;
    op_b = 8'd2;
    press_btn();
    wait_done("run_press");
    check_result("run_press");
    check_bit("run_press_err", o_err, 1'b1);
    check_int("run_press_episodes", start_episodes - ep0, 1);
    check_int("run_press_op_b_held", int'(o_op_b), 255);
    extra = 0;
  endtask

  task automatic test_req_timeout();
    int low0 = start_low_cycles;
    int n    = 0;
    stuck = 1'b1;
    op_a  = 8'd5;
    op_b  = 8'd5;
    press_btn();
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_bit("timeout_busy", o_busy, 1'b0);
    check_int("timeout_req_cycles", start_low_cycles - low0, 64);
    check_bit("timeout_start", o_start, 1'b1);
    check_bit("timeout_err", o_err, 1'b1);
    check_bit("timeout_valid", o_valid, 1'b0);
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    extra = 20;
    op_a  = 8'd7;
    op_b  = 8'd9;
    btn   = 1'b0;
    repeat (10) @(negedge clk);
    btn = 1'b1;
    while (!(o_busy && o_start) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_bit("midrun_in_run", o_busy && o_start, 1'b1);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_async");
    @(negedge clk);
    check_reset_outputs("midrun_held");
    rst_n = 1'b1;
    extra = 0;
    repeat (3) @(negedge clk);
    op_a = 8'd2;
    op_b = 8'd3;
    exp_q.push_back(16'd6);
    press_btn();
    wait_done("after_reset");
    check_result("after_reset");
    check_bit("after_reset_err", o_err, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_press_during_run();
    test_req_timeout();
    test_reset_mid_run();
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
